// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM accesses
// (low half-word first, then high half-word), each held on the pins for
// PHASE_CYCLES clocks. The ready output stalls the pipeline while the
// access is in flight.
// Optional feature: define SRAM_CTRL_RDBUF_EN to add a one-entry read
// buffer that answers repeated reads of the same word without touching
// the SRAM.
module sram_access_ctrl #(
    parameter logic [31:0] BASE_ADDR    = 32'd1024,
    parameter int          PHASE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
);

    localparam int CW = $clog2(PHASE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_write_q, is_write_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          req;
    logic          buf_hit;
    logic [31:0]   offset;
    logic [17:0]   word_addr;
    logic          drive_dq;
    logic [15:0]   dq_out;
    logic          unused_bits;

`ifdef SRAM_CTRL_RDBUF_EN
    logic          buf_valid_q, buf_valid_d;
    logic [29:0]   buf_tag_q, buf_tag_d;
    logic [31:0]   buf_data_q, buf_data_d;
    logic          tag_match;
`endif

    // Address mapping, buffer hit detection and all pin-level outputs
    always_comb begin
        req       = mem_r_en | mem_w_en;
        offset    = addr - BASE_ADDR;
        word_addr = {offset[18:2], 1'b0};
`ifdef SRAM_CTRL_RDBUF_EN
        tag_match = buf_valid_q & (buf_tag_q == addr[31:2]);
        buf_hit   = (state_q == IDLE) & mem_r_en & ~mem_w_en & tag_match;
`else
        buf_hit   = 1'b0;
`endif
        drive_dq  = is_write_q & ((state_q == LOW) | (state_q == HIGH));
        dq_out    = (state_q == HIGH) ? wdata[31:16] : wdata[15:0];
        SRAM_ADDR = (state_q == HIGH) ? (word_addr | 18'd1) : word_addr;
        SRAM_WE_N = ~drive_dq;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
        ready     = (state_q == DONE) | ((state_q == IDLE) & ~req) | buf_hit;
`ifdef SRAM_CTRL_RDBUF_EN
        rdata     = buf_hit ? buf_data_q : rdata_q;
`else
        rdata     = rdata_q;
`endif
    end

    assign SRAM_DQ     = drive_dq ? dq_out : 16'bz;
    assign unused_bits = ^{offset[31:19], offset[1:0], addr[1:0]};

    // Next-state logic: phase sequencing, half-word capture, buffer upkeep
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        rdata_d    = rdata_q;
`ifdef SRAM_CTRL_RDBUF_EN
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (buf_hit) begin
`ifdef SRAM_CTRL_RDBUF_EN
                    rdata_d = buf_data_q;
`endif
                end else if (req) begin
                    state_d    = LOW;
                    cnt_d      = '0;
                    is_write_d = mem_w_en;
                end
            end
            LOW: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    if (!is_write_q) begin
                        rdata_d[15:0] = SRAM_DQ;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HIGH: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!is_write_q) begin
                        rdata_d[31:16] = SRAM_DQ;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef SRAM_CTRL_RDBUF_EN
                if (!is_write_q) begin
                    buf_valid_d = 1'b1;
                    buf_tag_d   = addr[31:2];
                    buf_data_d  = rdata_q;
                end else if (tag_match) begin
                    buf_data_d  = wdata;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any access in flight immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
`ifdef SRAM_CTRL_RDBUF_EN
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            rdata_q    <= rdata_d;
`ifdef SRAM_CTRL_RDBUF_EN
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl
// Directed bench for sram_access_ctrl with a small behavioural SRAM model.
// Read-buffer expectations follow SRAM_CTRL_RDBUF_EN when it is defined.
module tb_sram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    logic [15:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_a;
    logic [15:0] pre_d;

    int checks = 0;
    int errors = 0;

    sram_access_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .mem_r_en  (mem_r_en),
        .mem_w_en  (mem_w_en),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_UB_N (sram_ub_n),
        .SRAM_LB_N (sram_lb_n),
        .SRAM_CE_N (sram_ce_n),
        .SRAM_OE_N (sram_oe_n),
        .SRAM_WE_N (sram_we_n)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    // SRAM model drives the bus whenever it is not being written
    assign sram_dq = sram_we_n ? mem[sram_addr[5:0]] : 16'hzzzz;

    // SRAM storage: bench preloads take priority over DUT writes
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_a] <= pre_d;
        end else if (!sram_we_n) begin
            mem[sram_addr[5:0]] <= sram_dq;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [15:0] d);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    // One request held until ready; last = cycle in which ready must rise
    task automatic apply_stimulus(input logic r, input logic w, input logic [31:0] a,
                                  input logic [31:0] d, input logic [17:0] base,
                                  input int last, input logic [31:0] exp_rdata);
        mem_r_en = r;
        mem_w_en = w;
        addr     = a;
        wdata    = d;
        for (int cyc = 0; cyc <= last; cyc++) begin
            @(negedge clk);
            check_output($sformatf("ready_c%0d", cyc), 32'(ready), 32'(cyc == last));
            if (cyc == 0) begin
                check_output("addr_c0", {14'b0, sram_addr}, {14'b0, base});
            end
            if (last > 0 && cyc >= 1 && cyc <= 4) begin
                check_output($sformatf("addr_c%0d", cyc), {14'b0, sram_addr},
                             {14'b0, (cyc >= 3) ? (base | 18'd1) : base});
                check_output($sformatf("we_n_c%0d", cyc), 32'(sram_we_n), 32'(!w));
                if (w) begin
                    check_output($sformatf("dq_c%0d", cyc), {16'b0, sram_dq},
                                 {16'b0, (cyc >= 3) ? d[31:16] : d[15:0]});
                end
            end
            if (cyc == last) begin
                check_output("rdata", rdata, exp_rdata);
            end
        end
        @(posedge clk);
        #1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        addr     = 32'd0;
        wdata    = 32'd0;
        pre_we   = 1'b0;
        pre_a    = 6'd0;
        pre_d    = 16'd0;
        $display("[TB] start");

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_ready", 32'(ready), 32'd1);
        check_output("rst_rdata", rdata, 32'd0);
        check_output("rst_we_n", 32'(sram_we_n), 32'd1);
        check_output("rst_ties", {28'b0, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Store then load of the base word
        apply_stimulus(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'd0, 5, 32'd0);
        apply_stimulus(1'b1, 1'b0, 32'd1024, 32'd0, 18'd0, 5, 32'hDEADBEEF);

        // Half-word assembly order
        preload(6'd2, 16'h1357);
        preload(6'd3, 16'h2468);
        apply_stimulus(1'b1, 1'b0, 32'd1028, 32'd0, 18'd2, 5, 32'h24681357);

        // Reset during the high phase of a store
        mem_w_en = 1'b1;
        addr     = 32'd1024;
        wdata    = 32'hCAFEF00D;
        @(negedge clk);
        repeat (3) @(negedge clk);
        check_output("hi_addr", {14'b0, sram_addr}, 32'd1);
        check_output("hi_we_n", 32'(sram_we_n), 32'd0);
        check_output("hi_dq", {16'b0, sram_dq}, 32'h0000CAFE);
        rst = 1'b0;
        #1;
        check_output("abort_we_n", 32'(sram_we_n), 32'd1);
        check_output("abort_ready", 32'(ready), 32'd0);
        check_output("abort_rdata", rdata, 32'd0);
        mem_w_en = 1'b0;
        #1;
        check_output("abort_idle", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply_stimulus(1'b1, 1'b0, 32'd1024, 32'd0, 18'd0, 5, 32'hDEADF00D);

        // Repeated read of one word, then write-through and re-read
        preload(6'd4, 16'h9ABC);
        preload(6'd5, 16'h7F00);
        apply_stimulus(1'b1, 1'b0, 32'd1032, 32'd0, 18'd4, 5, 32'h7F009ABC);
`ifdef SRAM_CTRL_RDBUF_EN
        apply_stimulus(1'b1, 1'b0, 32'd1032, 32'd0, 18'd4, 0, 32'h7F009ABC);
`else
        apply_stimulus(1'b1, 1'b0, 32'd1032, 32'd0, 18'd4, 5, 32'h7F009ABC);
`endif
        apply_stimulus(1'b0, 1'b1, 32'd1032, 32'h0BADCAFE, 18'd4, 5, 32'h7F009ABC);
`ifdef SRAM_CTRL_RDBUF_EN
        apply_stimulus(1'b1, 1'b0, 32'd1032, 32'd0, 18'd4, 0, 32'h0BADCAFE);
`else
        apply_stimulus(1'b1, 1'b0, 32'd1032, 32'd0, 18'd4, 5, 32'h0BADCAFE);
`endif

        // Simultaneous read and write requests act as a store
        apply_stimulus(1'b1, 1'b1, 32'd1036, 32'h12345678, 18'd6, 5, 32'h0BADCAFE);
        apply_stimulus(1'b1, 1'b0, 32'd1036, 32'd0, 18'd6, 5, 32'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
